// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit path: word width, frame width and default BCLK divider.
package i2s_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int FRAME_BITS  = 2 * SAMPLE_W;
   localparam int CLK_DIV_DEF = 32;

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: toggles BCLK every CLK_DIV system clocks.
// The strobes flag the cycle whose closing CLK edge flips BCLK.
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   output logic bclk,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bclk_q, bclk_d;
   logic             tc;

   always_comb begin
      tc     = (cnt_q == CNT_W'(CLK_DIV - 1));
      cnt_d  = tc ? '0 : cnt_q + 1'b1;
      bclk_d = tc ? ~bclk_q : bclk_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         bclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bclk_q <= bclk_d;
      end
   end

   assign bclk     = bclk_q;
   assign rise_stb = tc & ~bclk_q;
   assign fall_stb = tc & bclk_q;

endmodule

// File: rtl/i2s_serializer.sv
// Stereo I2S transmitter: one-entry pair buffer, 2*SAMPLE_W slot frame, MSB first with
// the standard one-BCLK data delay behind word select.
module i2s_serializer #(
   parameter int CLK_DIV  = i2s_pkg::CLK_DIV_DEF,
   parameter int SAMPLE_W = i2s_pkg::SAMPLE_W
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic [SAMPLE_W-1:0] sample_left,
   input  logic [SAMPLE_W-1:0] sample_right,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                DAC_I2S_CLK,
   output logic                DAC_I2S_WS,
   output logic                DAC_I2S_DATA,
   output logic                underrun
);

   localparam int FRAME_W = 2 * SAMPLE_W;
   localparam int SLOT_W  = $clog2(FRAME_W);

   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [FRAME_W-1:0] shreg_q, shreg_d;
   logic [FRAME_W-1:0] buf_q, buf_d;
   logic               full_q, full_d;
   logic               ready_q, ready_d;
   logic               ws_q, ws_d;
   logic               data_q, data_d;
   logic               underrun_q, underrun_d;

   logic bclk, rise_stb, fall_stb;
   logic frame_start, accept;
   logic unused_rise;

   i2s_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (CLK),
      .rst_n    (Reset),
      .bclk     (bclk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // Everything here moves on BCLK falling edges; the rising strobe has no consumer.
   assign unused_rise = rise_stb;

   always_comb begin
      accept      = sample_valid & ready_q;
      frame_start = fall_stb & (slot_q == SLOT_W'(FRAME_W - 1));

      slot_d     = slot_q;
      shreg_d    = shreg_q;
      ws_d       = ws_q;
      data_d     = data_q;
      full_d     = full_q;
      buf_d      = buf_q;
      underrun_d = 1'b0;

      if (fall_stb) begin
         slot_d  = frame_start ? '0 : slot_q + 1'b1;
         ws_d    = (slot_d >= SLOT_W'(SAMPLE_W));
         // Top bit is the frame bit due one slot late; at frame start it is the old right LSB.
         data_d  = shreg_q[FRAME_W-1];
         shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      end

      if (frame_start) begin
         shreg_d    = full_q ? buf_q : '0;
         full_d     = 1'b0;
         underrun_d = ~full_q;
      end

      // ready_q is low whenever the buffer is full, so a capture never collides with a load.
      if (accept) begin
         buf_d  = {sample_left, sample_right};
         full_d = 1'b1;
      end

      ready_d = ~full_d;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         slot_q     <= '0;
         shreg_q    <= '0;
         buf_q      <= '0;
         full_q     <= 1'b0;
         ready_q    <= 1'b0;
         ws_q       <= 1'b0;
         data_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         shreg_q    <= shreg_d;
         buf_q      <= buf_d;
         full_q     <= full_d;
         ready_q    <= ready_d;
         ws_q       <= ws_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   assign sample_ready = ready_q;
   assign DAC_I2S_CLK  = bclk;
   assign DAC_I2S_WS   = ws_q;
   assign DAC_I2S_DATA = data_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: a CLK_DIV=32 and a CLK_DIV=2 instance compared every cycle
// against a frame-level model of the I2S stream, plus directed scenario checks.
module tb_i2s_serializer;
   import i2s_pkg::*;

   localparam int DIV_A = 32;
   localparam int DIV_B = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_a_n = 1'b1, rst_b_n = 1'b1;
   logic [SAMPLE_W-1:0] l_a = '0, r_a = '0, l_b = '0, r_b = '0;
   logic                v_a = 1'b0, v_b = 1'b0;
   logic                rdy_a, bclk_a, ws_a, dat_a, und_a;
   logic                rdy_b, bclk_b, ws_b, dat_b, und_b;

   i2s_serializer #(.CLK_DIV(DIV_A), .SAMPLE_W(SAMPLE_W)) u_dut_a (
      .CLK(clk), .Reset(rst_a_n), .sample_left(l_a), .sample_right(r_a),
      .sample_valid(v_a), .sample_ready(rdy_a), .DAC_I2S_CLK(bclk_a),
      .DAC_I2S_WS(ws_a), .DAC_I2S_DATA(dat_a), .underrun(und_a));

   i2s_serializer #(.CLK_DIV(DIV_B), .SAMPLE_W(SAMPLE_W)) u_dut_b (
      .CLK(clk), .Reset(rst_b_n), .sample_left(l_b), .sample_right(r_b),
      .sample_valid(v_b), .sample_ready(rdy_b), .DAC_I2S_CLK(bclk_b),
      .DAC_I2S_WS(ws_b), .DAC_I2S_DATA(dat_b), .underrun(und_b));

   // Model state: edges since release, buffered pair, current and previous frame words.
   typedef struct {
      int                    e;
      int                    slot;
      logic                  full;
      logic                  und;
      logic                  rdy;
      logic [FRAME_BITS-1:0] buf_w;
      logic [FRAME_BITS-1:0] cur;
      logic [FRAME_BITS-1:0] prev;
   } mdl_t;

   mdl_t ma, mb;
   int   n_chk = 0, n_pass = 0;
   int   cyc = 0;
   int   nfall_a = 0, nfall_b = 0, last_a = -1, last_b = -1, per_a = 0, per_b = 0;
   int   nund_a = 0, nund_b = 0, acc_b = 0;
   logic bclk_pa = 1'b0, bclk_pb = 1'b0;
   logic [31:0] cap_a = '0;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.e = 0; m.slot = 0; m.full = 1'b0; m.und = 1'b0; m.rdy = 1'b0;
      m.buf_w = '0; m.cur = '0; m.prev = '0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int div, logic v,
                                     logic [SAMPLE_W-1:0] l, logic [SAMPLE_W-1:0] r);
      logic acc;
      acc   = v && m.rdy;
      m.e   = m.e + 1;
      m.und = 1'b0;
      if (m.e % (2 * div) == 0) begin
         m.slot = (m.e / (2 * div)) % FRAME_BITS;
         if (m.slot == 0) begin
            m.prev = m.cur;
            if (m.full) begin
               m.cur  = m.buf_w;
               m.full = 1'b0;
            end else begin
               m.cur = '0;
               m.und = 1'b1;
            end
         end
      end
      if (acc) begin
         m.buf_w = {l, r};
         m.full  = 1'b1;
      end
      m.rdy = !m.full;
      return m;
   endfunction

   // Expected {BCLK, WS, DATA, underrun, ready}.
   function automatic logic [4:0] mdl_out(mdl_t m, int div);
      logic [4:0] o;
      o[4] = ((m.e / div) % 2) == 1;
      o[3] = (m.slot >= SAMPLE_W);
      o[2] = (m.slot == 0) ? m.prev[0] : m.cur[FRAME_BITS - m.slot];
      o[1] = m.und;
      o[0] = m.rdy;
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cyc %0d: got %h, expected %h", tag, cyc, got, exp);
   endtask

   task automatic cycle();
      if (rst_b_n && v_b && rdy_b) acc_b++;
      @(posedge clk);
      ma = rst_a_n ? mdl_step(ma, DIV_A, v_a, l_a, r_a) : mdl_reset();
      mb = rst_b_n ? mdl_step(mb, DIV_B, v_b, l_b, r_b) : mdl_reset();
      @(negedge clk);
      cyc++;
      check("out_a", {27'd0, bclk_a, ws_a, dat_a, und_a, rdy_a}, {27'd0, mdl_out(ma, DIV_A)});
      check("out_b", {27'd0, bclk_b, ws_b, dat_b, und_b, rdy_b}, {27'd0, mdl_out(mb, DIV_B)});
      if (!rst_a_n) begin
         nfall_a = 0; last_a = -1;
      end else if (bclk_pa && !bclk_a) begin
         nfall_a++;
         if (last_a >= 0) per_a = cyc - last_a;
         last_a = cyc;
         if (nfall_a >= 33 && nfall_a <= 64) cap_a = {cap_a[30:0], dat_a};
      end
      if (!rst_b_n) begin
         nfall_b = 0; last_b = -1;
      end else if (bclk_pb && !bclk_b) begin
         nfall_b++;
         if (last_b >= 0) per_b = cyc - last_b;
         last_b = cyc;
      end
      bclk_pa = bclk_a;
      bclk_pb = bclk_b;
      if (und_a) nund_a++;
      if (und_b) nund_b++;
   endtask

   task automatic wait_fall_a(input int tgt);
      int g = 0;
      while (nfall_a < tgt && g < 20000) begin cycle(); g++; end
      check("wait_fall_a", 32'(nfall_a >= tgt), 32'd1);
   endtask

   task automatic wait_fall_b(input int tgt);
      int g = 0;
      while (nfall_b < tgt && g < 5000) begin cycle(); g++; end
      check("wait_fall_b", 32'(nfall_b >= tgt), 32'd1);
   endtask

   initial begin
      int g;
      int f0;
      ma = mdl_reset();
      mb = mdl_reset();
      #1;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (3) cycle();
      check("rst_outs_a", {27'd0, bclk_a, ws_a, dat_a, und_a, rdy_a}, 32'd0);

      // Instance A: one pair pushed before the first frame start, then idle frames.
      rst_a_n = 1'b1;
      v_a = 1'b1; l_a = 16'hA5C3; r_a = 16'h0F01;
      cycle();
      check("rdy_first_edge", {31'd0, rdy_a}, 32'd1);
      repeat (2) cycle();
      v_a = 1'b0; l_a = '0; r_a = '0;
      wait_fall_a(4 * FRAME_BITS + 1);
      check("frame_a5c3", cap_a, 32'hA5C30F01);
      check("und_cnt_a", 32'(nund_a), 32'd3);

      // Instance B: right word of all ones, LSB must appear in slot 0 of the next frame.
      rst_b_n = 1'b1;
      v_b = 1'b1; l_b = '0; r_b = 16'hFFFF;
      repeat (3) cycle();
      v_b = 1'b0;
      wait_fall_b(2 * FRAME_BITS);
      check("rlsb_carry", {31'd0, dat_b}, 32'd1);

      // Valid arriving exactly on an empty frame start.
      g = 0;
      while (!(((mb.e + 1) % (FRAME_BITS * 2 * DIV_B)) == 0 && !mb.full) && g < 1000) begin
         cycle(); g++;
      end
      check("align_031", 32'(g < 1000), 32'd1);
      v_b = 1'b1; l_b = 16'h8000; r_b = '0;
      cycle();
      v_b = 1'b0;
      check("und_031", {31'd0, und_b}, 32'd1);
      f0 = nfall_b;
      wait_fall_b(f0 + FRAME_BITS + 1);
      check("slot1_031", {31'd0, dat_b}, 32'd1);

      // Back-to-back pairs with valid held high and data changing every cycle.
      v_b = 1'b1;
      repeat (2 * FRAME_BITS * 2 * DIV_B) begin
         l_b = SAMPLE_W'($urandom); r_b = SAMPLE_W'($urandom); cycle();
      end
      g = 0;
      while ((mb.e % (FRAME_BITS * 2 * DIV_B)) != 0 && g < 1000) begin
         l_b = SAMPLE_W'($urandom); r_b = SAMPLE_W'($urandom); cycle(); g++;
      end
      nund_b = 0; acc_b = 0;
      repeat (8 * FRAME_BITS * 2 * DIV_B) begin
         l_b = SAMPLE_W'($urandom); r_b = SAMPLE_W'($urandom); cycle();
      end
      check("und_b2b", 32'(nund_b), 32'd0);
      check("acc_b2b", 32'(acc_b), 32'd8);

      // Reset mid-frame at slot 9 with the buffer holding a pair.
      g = 0;
      while (!(mb.slot == 9 && mb.full) && g < 2000) begin
         l_b = SAMPLE_W'($urandom); r_b = SAMPLE_W'($urandom); cycle(); g++;
      end
      check("reach_slot9", 32'(g < 2000), 32'd1);
      v_b = 1'b0;
      rst_b_n = 1'b0;
      mb = mdl_reset();
      #1;
      check("rst_async_b", {27'd0, bclk_b, ws_b, dat_b, und_b, rdy_b}, 32'd0);
      repeat (3) cycle();
      rst_b_n = 1'b1;
      cycle();
      check("rdy_after_rst", {31'd0, rdy_b}, 32'd1);
      nund_b = 0;
      repeat (200) cycle();
      check("und_after_rst", 32'(nund_b), 32'd1);

      // Random traffic: bursty valid, data wiggling while stalled, frequent all-ones right words.
      repeat (40 * FRAME_BITS * 2 * DIV_B) begin
         v_b = ($urandom_range(0, 3) != 0);
         l_b = SAMPLE_W'($urandom);
         r_b = ($urandom_range(0, 3) == 0) ? '1 : SAMPLE_W'($urandom);
         cycle();
      end

      check("bclk_per_a", 32'(per_a), 32'(2 * DIV_A));
      check("bclk_per_b", 32'(per_b), 32'(2 * DIV_B));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
